// File: rtl/mdu_if.sv
// Operand/result bundle between the E stage and the multiply/divide unit.
// Combinational signal group only, so it adds no latency.
// No flow control: the E stage must hold off md_start while busy is high.
interface mdu_if;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  md_op;
    logic        md_start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    // E-stage side: drives operands and the start strobe, observes HI/LO/busy
    modport master (
        output SrcA, SrcB, md_op, md_start,
        input  busy, HI, LO
    );

    // Unit side
    modport slave (
        input  SrcA, SrcB, md_op, md_start,
        output busy, HI, LO
    );
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit: computes mult/multu/div/divu at accept, then commits to HI/LO after a busy count.
// Latency: MULT_CYCLES or DIV_CYCLES busy cycles; mthi/mtlo write HI/LO on the next edge.
// Backpressure: busy=1 while in flight; any md_start seen while busy is dropped. Macro MDU_MADD_EN enables madd/maddu.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  md
);
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
`endif

    // Architectural and in-flight state
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [31:0]      hi_q,   hi_d;
    logic [31:0]      lo_q,   lo_d;
    logic [31:0]      phi_q,  phi_d;
    logic [31:0]      plo_q,  plo_d;
    logic             wr_q,   wr_d;   // pending result is committed (clear on divide by zero)
    logic             acc_q,  acc_d;  // pending result is added to HI/LO rather than written

    // Datapath temporaries
    logic [63:0] a_sx, b_sx, a_zx, b_zx;
    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
    logic        is_mult, is_div, is_madd;

    // Result generation for every op; division runs on magnitudes so the
    // most-negative/-1 case needs no special handling and never overflows
    always_comb begin
        a_sx   = {{32{md.SrcA[31]}}, md.SrcA};
        b_sx   = {{32{md.SrcB[31]}}, md.SrcB};
        a_zx   = {32'h0, md.SrcA};
        b_zx   = {32'h0, md.SrcB};
        prod_s = a_sx * b_sx;
        prod_u = a_zx * b_zx;

        a_neg  = (md.md_op == OP_DIV) && md.SrcA[31];
        b_neg  = (md.md_op == OP_DIV) && md.SrcB[31];
        a_mag  = a_neg ? (32'h0 - md.SrcA) : md.SrcA;
        b_mag  = b_neg ? (32'h0 - md.SrcB) : md.SrcB;
        q_mag  = (b_mag == 32'h0) ? 32'h0 : (a_mag / b_mag);
        r_mag  = (b_mag == 32'h0) ? 32'h0 : (a_mag % b_mag);
        quot   = (a_neg ^ b_neg) ? (32'h0 - q_mag) : q_mag;
        rem    = a_neg ? (32'h0 - r_mag) : r_mag;

        is_mult = (md.md_op == OP_MULT) || (md.md_op == OP_MULTU);
        is_div  = (md.md_op == OP_DIV)  || (md.md_op == OP_DIVU);
`ifdef MDU_MADD_EN
        is_madd = (md.md_op == OP_MADD) || (md.md_op == OP_MADDU);
`else
        is_madd = 1'b0;
`endif
    end

    // Next-state: commit on the last busy cycle, otherwise accept a new op when idle
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        phi_d  = phi_q;
        plo_d  = plo_q;
        wr_d   = wr_q;
        acc_d  = acc_q;

        if (busy_q) begin
            // Requests arriving now are dropped so counter and pending stay intact
            if (cnt_q == CNT_ONE) begin
                busy_d = 1'b0;
                cnt_d  = '0;
                if (wr_q) begin
                    if (acc_q) begin
                        {hi_d, lo_d} = {hi_q, lo_q} + {phi_q, plo_q};
                    end else begin
                        {hi_d, lo_d} = {phi_q, plo_q};
                    end
                end
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else if (md.md_start) begin
            if (is_mult || is_madd) begin
                // Signed ops are 1 (mult) and 7 (madd); both have bit0 set
                {phi_d, plo_d} = md.md_op[0] ? prod_s : prod_u;
                wr_d   = 1'b1;
                acc_d  = is_madd;
                cnt_d  = MULT_LOAD;
                busy_d = 1'b1;
            end else if (is_div) begin
                {phi_d, plo_d} = {rem, quot};
                wr_d   = (md.SrcB != 32'h0);
                acc_d  = 1'b0;
                cnt_d  = DIV_LOAD;
                busy_d = 1'b1;
            end else if (md.md_op == OP_MTHI) begin
                hi_d = md.SrcA;
            end else if (md.md_op == OP_MTLO) begin
                lo_d = md.SrcA;
            end
        end
    end

    // State registers, all cleared by reset so an aborted op never writes back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= 32'h0;
            lo_q   <= 32'h0;
            phi_q  <= 32'h0;
            plo_q  <= 32'h0;
            wr_q   <= 1'b0;
            acc_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            phi_q  <= phi_d;
            plo_q  <= plo_d;
            wr_q   <= wr_d;
            acc_q  <= acc_d;
        end
    end

    assign md.busy = busy_q;
    assign md.HI   = hi_q;
    assign md.LO   = lo_q;
endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: directed vector table, hand sequences for reset/overlap/madd, random ops vs model.
// Checks HI/LO and busy length at the cycle busy first drops.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_mdu;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_if bus ();

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
        end
    endtask

    // Reference: arithmetic straight from the instruction definitions
    task automatic model_step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] hi, output logic [31:0] lo, output int cyc);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, uq, ur, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        hi = m_hi;
        lo = m_lo;
        cyc = 0;
        case (op)
            4'd1: begin p = 64'(sa * sb); {hi, lo} = p; cyc = 5; end
            4'd2: begin p = ua * ub; {hi, lo} = p; cyc = 5; end
            4'd3: begin
                cyc = 10;
                if (b != 0) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    lo = sq[31:0];
                    hi = sr[31:0];
                end
            end
            4'd4: begin
                cyc = 10;
                if (b != 0) begin
                    uq = ua / ub;
                    ur = ua % ub;
                    lo = uq[31:0];
                    hi = ur[31:0];
                end
            end
            4'd5: hi = a;
            4'd6: lo = a;
`ifdef MDU_MADD_EN
            4'd7: begin p = 64'(sa * sb); {hi, lo} = {m_hi, m_lo} + p; cyc = 5; end
            4'd8: begin p = ua * ub; {hi, lo} = {m_hi, m_lo} + p; cyc = 5; end
`endif
            default: ;
        endcase
    endtask

    // Issue one op, check no early visibility, count busy cycles, check result
    task automatic run_and_check(input string nm, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] ehi,
                                 input logic [31:0] elo, input int ecyc);
        int cyc;
        cyc = 0;
        @(negedge clk);
        bus.md_op    = op;
        bus.SrcA     = a;
        bus.SrcB     = b;
        bus.md_start = 1'b1;
        @(negedge clk);
        bus.md_start = 1'b0;
        bus.md_op    = 4'd0;
        bus.SrcA     = $urandom;
        bus.SrcB     = $urandom;
        if (ecyc > 0)
            chk({nm, "_nobypass"}, {bus.HI, bus.LO}, {m_hi, m_lo});
        while (bus.busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        chk({nm, "_busycyc"}, 64'(cyc), 64'(ecyc));
        chk({nm, "_hilo"}, {bus.HI, bus.LO}, {ehi, elo});
        m_hi = ehi;
        m_lo = elo;
    endtask

    task automatic model_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b);
        logic [31:0] ehi, elo;
        int          ecyc;
        model_step(op, a, b, ehi, elo, ecyc);
        run_and_check(nm, op, a, b, ehi, elo, ecyc);
    endtask

    initial begin
        int          cyc;
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        int          sel;

        vectors     = 0;
        miscompares = 0;
        m_hi        = 32'h0;
        m_lo        = 32'h0;

        tbl[0]  = '{4'd1, 32'hFFFFFFFD, 32'h5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
        tbl[1]  = '{4'd2, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 5};
        tbl[2]  = '{4'd3, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        tbl[3]  = '{4'd5, 32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFD, 0};
        tbl[4]  = '{4'd6, 32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 0};
        tbl[5]  = '{4'd4, 32'h00000055, 32'h0,        32'h12345678, 32'h9ABCDEF0, 10};
        tbl[6]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        tbl[7]  = '{4'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        tbl[8]  = '{4'd4, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 10};
        tbl[9]  = '{4'd0, 32'hDEADBEEF, 32'h3,        32'h0000000F, 32'h0FFFFFFF, 0};
        tbl[10] = '{4'd9, 32'hDEADBEEF, 32'h3,        32'h0000000F, 32'h0FFFFFFF, 0};
        tbl[11] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

        bus.md_start = 1'b0;
        bus.md_op    = 4'd0;
        bus.SrcA     = 32'h0;
        bus.SrcB     = 32'h0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_hilo", {bus.HI, bus.LO}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            run_and_check($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                          tbl[i].hi, tbl[i].lo, tbl[i].cyc);

        // Reset on busy cycle 2 aborts the multiply with no late write
        @(negedge clk);
        bus.md_op = 4'd1; bus.SrcA = 32'd3; bus.SrcB = 32'd4; bus.md_start = 1'b1;
        @(negedge clk);
        bus.md_start = 1'b0; bus.md_op = 4'd0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        chk("rst_mid_hilo", {bus.HI, bus.LO}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("rst_after_busy", 64'(bus.busy), 64'd0);
        chk("rst_after_hilo", {bus.HI, bus.LO}, 64'd0);
        m_hi = 32'h0;
        m_lo = 32'h0;

        // A div strobe during busy cycle 1 must be ignored
        @(negedge clk);
        bus.md_op = 4'd1; bus.SrcA = 32'd2; bus.SrcB = 32'd3; bus.md_start = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (bus.busy && cyc < 200) begin
            cyc++;
            if (cyc == 1) begin
                bus.md_op = 4'd3; bus.SrcA = 32'd100; bus.SrcB = 32'd7; bus.md_start = 1'b1;
            end else begin
                bus.md_start = 1'b0; bus.md_op = 4'd0;
            end
            @(negedge clk);
        end
        bus.md_start = 1'b0; bus.md_op = 4'd0;
        chk("overlap_busycyc", 64'(cyc), 64'd5);
        chk("overlap_hilo", {bus.HI, bus.LO}, {32'h0, 32'h6});
        repeat (12) @(negedge clk);
        chk("overlap_late", {bus.HI, bus.LO}, {32'h0, 32'h6});
        m_hi = 32'h0;
        m_lo = 32'h6;

        // Accumulate ops (or their absence in the default build)
        model_op("set_hi", 4'd5, 32'h0, 32'h0);
        model_op("set_lo", 4'd6, 32'hFFFFFFFF, 32'h0);
`ifdef MDU_MADD_EN
        run_and_check("maddu", 4'd8, 32'd1, 32'd1, 32'h1, 32'h0, 5);
        run_and_check("madd", 4'd7, 32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFF, 5);
`else
        run_and_check("maddu_off", 4'd8, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 0);
        run_and_check("madd_off", 4'd7, 32'd5, 32'd5, 32'h0, 32'hFFFFFFFF, 0);
`endif

        // Random ops against the arithmetic model
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 11);
            if (sel < 8)       rop = 4'(sel + 1);
            else if (sel == 8) rop = 4'd0;
            else if (sel == 9) rop = 4'($urandom_range(9, 15));
            else               rop = 4'($urandom_range(3, 4));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = 32'($urandom_range(1, 9));
                2: ra = 32'h80000000;
                3: rb = 32'hFFFFFFFF;
                default: ;
            endcase
            model_op($sformatf("rnd%0d_op%0d", n, rop), rop, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
